// File: rtl/sprite_layer_mapper.sv
// -----------------------------------------------------------------------------
// sprite_layer_mapper
//   Multi-sprite colour mapper for the VGA pixel path. For each active pixel it
//   decides which sprite (if any) covers the scan position and emits registered
//   24-bit RGB two cycles later. Sprite 0 has the highest priority. Pixels that
//   no sprite covers get a blue gradient that darkens from left to right.
//   Sprite descriptors are copied into shadow registers on frame_start, so a
//   frame is always drawn from one consistent snapshot.
//
// Ports
//   Clk, Reset_n          pixel clock, async active-low reset
//   frame_start           one-cycle pulse at the start of vertical blank
//   pix_valid             DrawX/DrawY is an active-area pixel this cycle
//   DrawX, DrawY          scan position
//   SprX/SprY/SprSize     packed per sprite, sprite i at [i*COORD_W +: COORD_W]
//   SprColor              packed {R,G,B} per sprite, sprite i at [i*24 +: 24]
//   SprEn/SprCircle/SprBlink  per-sprite enable, circle shape, blink enable
//   Red/Green/Blue        registered pixel colour
//   rgb_valid             Red/Green/Blue belong to a valid pixel
// -----------------------------------------------------------------------------
module sprite_layer_mapper #(
  parameter int          N_SPRITES    = 4,
  parameter int          COORD_W      = 10,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [7:0]  BG_BLUE      = 8'h7f
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_start,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic [N_SPRITES*COORD_W-1:0]   SprX,
  input  logic [N_SPRITES*COORD_W-1:0]   SprY,
  input  logic [N_SPRITES*COORD_W-1:0]   SprSize,
  input  logic [N_SPRITES*24-1:0]        SprColor,
  input  logic [N_SPRITES-1:0]           SprEn,
  input  logic [N_SPRITES-1:0]           SprCircle,
  input  logic [N_SPRITES-1:0]           SprBlink,
  output logic [7:0]                     Red,
  output logic [7:0]                     Green,
  output logic [7:0]                     Blue,
  output logic                           rgb_valid
);

  // Signed offsets need one extra bit; squared distances need 2*(COORD_W+1).
  localparam int DW    = COORD_W + 1;
  localparam int SQ_W  = 2 * COORD_W + 2;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  // Background arithmetic width: wide enough for both BG_BLUE and DrawX[MSB:3].
  localparam int BW    = (COORD_W - 3 > 8) ? (COORD_W - 3) : 8;

  // ---------------------------------------------------------------------------
  // Shadow sprite state, captured on frame_start
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0]   sh_x     [N_SPRITES];
  logic [COORD_W-1:0]   sh_y     [N_SPRITES];
  logic [COORD_W-1:0]   sh_size  [N_SPRITES];
  logic [23:0]          sh_color [N_SPRITES];
  logic [N_SPRITES-1:0] sh_en;
  logic [N_SPRITES-1:0] sh_circle;
  logic [N_SPRITES-1:0] sh_blink;

  // NOTE: the shadow arrays are deliberately reset (not left as uninitialised
  // storage) so that no sprite can be drawn before the first frame_start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sh_x[i]     <= '0;
        sh_y[i]     <= '0;
        sh_size[i]  <= '0;
        sh_color[i] <= '0;
      end
      sh_en     <= '0;
      sh_circle <= '0;
      sh_blink  <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sh_x[i]     <= SprX[i*COORD_W +: COORD_W];
        sh_y[i]     <= SprY[i*COORD_W +: COORD_W];
        sh_size[i]  <= SprSize[i*COORD_W +: COORD_W];
        sh_color[i] <= SprColor[i*24 +: 24];
      end
      sh_en     <= SprEn;
      sh_circle <= SprCircle;
      sh_blink  <= SprBlink;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame counter and blink phase
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] frame_cnt;
  logic             blink_phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: signed offsets. The per-sprite attributes used in stage 2 travel
  // with the pixel, so a frame_start between the stages cannot mix snapshots.
  // ---------------------------------------------------------------------------
  logic                 s1_valid;
  logic [COORD_W-1:0]   s1_x;
  logic signed [DW-1:0] s1_dx    [N_SPRITES];
  logic signed [DW-1:0] s1_dy    [N_SPRITES];
  logic [COORD_W-1:0]   s1_size  [N_SPRITES];
  logic [23:0]          s1_color [N_SPRITES];
  logic [N_SPRITES-1:0] s1_circle;
  logic [N_SPRITES-1:0] s1_live;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_circle <= '0;
      s1_live   <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        s1_dx[i]    <= '0;
        s1_dy[i]    <= '0;
        s1_size[i]  <= '0;
        s1_color[i] <= '0;
      end
    end else begin
      s1_valid  <= pix_valid;
      s1_x      <= DrawX;
      s1_circle <= sh_circle;
      // A blinking sprite is treated as disabled during the off phase.
      s1_live   <= sh_en & ~(sh_blink & {N_SPRITES{blink_phase}});
      for (int i = 0; i < N_SPRITES; i++) begin
        s1_dx[i]    <= $signed({1'b0, DrawX}) - $signed({1'b0, sh_x[i]});
        s1_dy[i]    <= $signed({1'b0, DrawY}) - $signed({1'b0, sh_y[i]});
        s1_size[i]  <= sh_size[i];
        s1_color[i] <= sh_color[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: hit test, priority, background
  // ---------------------------------------------------------------------------
  // Magnitude of a two's-complement offset; the most negative value maps to
  // its true magnitude because the result is read as unsigned.
  function automatic logic [DW-1:0] mag(input logic signed [DW-1:0] v);
    logic [DW-1:0] u;
    u = v;
    return v[DW-1] ? (~u) + DW'(1) : u;
  endfunction

  logic [DW-1:0]        ax      [N_SPRITES];
  logic [DW-1:0]        ay      [N_SPRITES];
  logic [SQ_W-1:0]      dist_sq [N_SPRITES];
  logic [SQ_W-1:0]      rad_sq  [N_SPRITES];
  logic [N_SPRITES-1:0] hit;
  logic [BW-1:0]        x_coarse;
  logic [BW-1:0]        bg_wide;
  logic [7:0]           bg_blue;
  logic [23:0]          pix_rgb;

  // NOTE: every variable written here gets a value on every path (defaults
  // first), which keeps this block purely combinational with no latches.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      ax[i]      = mag(s1_dx[i]);
      ay[i]      = mag(s1_dy[i]);
      dist_sq[i] = SQ_W'(ax[i]) * SQ_W'(ax[i]) + SQ_W'(ay[i]) * SQ_W'(ay[i]);
      rad_sq[i]  = SQ_W'(s1_size[i]) * SQ_W'(s1_size[i]);
      if (s1_circle[i])
        hit[i] = s1_live[i] && (dist_sq[i] <= rad_sq[i]);
      else
        hit[i] = s1_live[i] && (ax[i] <= DW'(s1_size[i])) && (ay[i] <= DW'(s1_size[i]));
    end

    // Gradient blue, clamped at zero instead of wrapping.
    x_coarse = BW'(s1_x[COORD_W-1:3]);
    bg_wide  = BW'(BG_BLUE);
    bg_blue  = (x_coarse > bg_wide) ? 8'd0 : 8'(bg_wide - x_coarse);

    // Walk from the highest index down so the lowest hitting index wins.
    pix_rgb = {16'h0000, bg_blue};
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) pix_rgb = s1_color[i];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      rgb_valid <= 1'b0;
    end else if (s1_valid) begin
      {Red, Green, Blue} <= pix_rgb;
      rgb_valid          <= 1'b1;
    end else begin
      // Blanking: nothing leaks out between active pixels.
      {Red, Green, Blue} <= '0;
      rgb_valid          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_layer_mapper.sv
// -----------------------------------------------------------------------------
// tb_sprite_layer_mapper
//   Self-checking bench for sprite_layer_mapper (N_SPRITES=4, COORD_W=10,
//   BLINK_FRAMES=2). A behavioural model computes each pixel's colour from the
//   sprite rules with integer arithmetic; expectations wait in a queue and are
//   compared against the DUT two cycles after the pixel is presented.
// -----------------------------------------------------------------------------
module tb_sprite_layer_mapper;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int BF = 2;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            frame_start = 1'b0;
  logic            pix_valid = 1'b0;
  logic [CW-1:0]   DrawX = '0;
  logic [CW-1:0]   DrawY = '0;
  logic [N*CW-1:0] SprX = '0;
  logic [N*CW-1:0] SprY = '0;
  logic [N*CW-1:0] SprSize = '0;
  logic [N*24-1:0] SprColor = '0;
  logic [N-1:0]    SprEn = '0;
  logic [N-1:0]    SprCircle = '0;
  logic [N-1:0]    SprBlink = '0;
  logic [7:0]      Red, Green, Blue;
  logic            rgb_valid;

  sprite_layer_mapper #(
    .N_SPRITES(N), .COORD_W(CW), .BLINK_FRAMES(BF), .BG_BLUE(8'h7f)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .SprX(SprX), .SprY(SprY), .SprSize(SprSize),
    .SprColor(SprColor), .SprEn(SprEn), .SprCircle(SprCircle), .SprBlink(SprBlink),
    .Red(Red), .Green(Green), .Blue(Blue), .rgb_valid(rgb_valid)
  );

  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int          m_x [N];
  int          m_y [N];
  int          m_s [N];
  logic [23:0] m_c [N];
  bit          m_en [N];
  bit          m_circ [N];
  bit          m_blink [N];
  int          m_frames;     // frame_start pulses since reset

  typedef struct {
    bit          v;
    logic [23:0] rgb;
    int          px;
    int          py;
  } exp_t;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string cur = "";

  function automatic exp_t ref_pixel(input int px, input int py, input bit pv);
    exp_t e;
    bit   off_phase;
    int   b, dx, dy;
    bit   h;
    e.v = pv; e.rgb = 24'h0; e.px = px; e.py = py;
    if (!pv) return e;
    off_phase = ((m_frames / BF) % 2) == 1;
    for (int i = 0; i < N; i++) begin
      if (m_en[i] && !(m_blink[i] && off_phase)) begin
        dx = px - m_x[i];
        dy = py - m_y[i];
        if (m_circ[i]) h = (dx*dx + dy*dy) <= m_s[i]*m_s[i];
        else           h = (dx <= m_s[i]) && (-dx <= m_s[i]) && (dy <= m_s[i]) && (-dy <= m_s[i]);
        if (h) begin
          e.rgb = m_c[i];
          return e;
        end
      end
    end
    b = 127 - px / 8;
    if (b < 0) b = 0;
    e.rgb = 24'(b);
    return e;
  endfunction

  task automatic set_spr(input int i, input int x, input int y, input int s,
                         input logic [23:0] c, input bit en, input bit circ, input bit blink);
    SprX[i*CW +: CW]    = CW'(x);
    SprY[i*CW +: CW]    = CW'(y);
    SprSize[i*CW +: CW] = CW'(s);
    SprColor[i*24 +: 24] = c;
    SprEn[i]     = en;
    SprCircle[i] = circ;
    SprBlink[i]  = blink;
  endtask

  // One clock: present inputs, record expectation, advance, compare the pixel
  // that was presented one call earlier (now at the output registers).
  task automatic cycle(input bit fs, input bit pv, input int px, input int py);
    exp_t e;
    frame_start = fs;
    pix_valid   = pv;
    DrawX       = CW'(px);
    DrawY       = CW'(py);
    exp_q.push_back(ref_pixel(px, py, pv));
    if (fs) begin
      for (int i = 0; i < N; i++) begin
        m_x[i]     = int'(SprX[i*CW +: CW]);
        m_y[i]     = int'(SprY[i*CW +: CW]);
        m_s[i]     = int'(SprSize[i*CW +: CW]);
        m_c[i]     = SprColor[i*24 +: 24];
        m_en[i]    = SprEn[i];
        m_circ[i]  = SprCircle[i];
        m_blink[i] = SprBlink[i];
      end
      m_frames++;
    end
    @(posedge Clk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      checks++;
      if ({rgb_valid, Red, Green, Blue} !== {e.v, e.rgb}) begin
        errors++;
        $display("FAIL %s pixel(%0d,%0d): got valid=%0b rgb=%06h, expected valid=%0b rgb=%06h",
                 cur, e.px, e.py, rgb_valid, {Red, Green, Blue}, e.v, e.rgb);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 0);
  endtask

  // Assert reset away from the clock edge, check outputs clear immediately,
  // release, and expect the flushed pipeline to produce a blank output.
  task automatic do_reset();
    exp_t z;
    Reset_n = 1'b0;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    #2;
    checks++;
    if ({rgb_valid, Red, Green, Blue} !== 25'h0) begin
      errors++;
      $display("FAIL %s reset_outputs: got valid=%0b rgb=%06h, expected valid=0 rgb=000000",
               cur, rgb_valid, {Red, Green, Blue});
    end
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_s[i] = 0; m_c[i] = 24'h0;
      m_en[i] = 1'b0; m_circ[i] = 1'b0; m_blink[i] = 1'b0;
    end
    m_frames = 0;
    exp_q.delete();
    z.v = 1'b0; z.rgb = 24'h0; z.px = -1; z.py = -1;
    exp_q.push_back(z);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    cur = "reset";
    SprEn = '0;
    set_spr(0, 100, 100, 4, 24'hff5500, 1'b1, 1'b0, 1'b0);
    do_reset();
    // No frame_start yet: shadow enables are clear, so only background.
    cycle(1'b0, 1'b1, 80, 100);
    cycle(1'b0, 1'b1, 100, 100);
    cycle(1'b0, 1'b1, 96, 104);
    cycle(1'b0, 1'b0, 100, 100);
    idle(2);
  endtask

  task automatic test_square();
    cur = "square";
    set_spr(0, 100, 100, 4, 24'hff5500, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 96, 104);
    cycle(1'b0, 1'b1, 95, 100);
    cycle(1'b0, 1'b1, 104, 96);
    cycle(1'b0, 1'b1, 105, 100);
    cycle(1'b0, 1'b1, 100, 105);
    cycle(1'b0, 1'b0, 100, 100);
    cycle(1'b0, 1'b1, 100, 100);
    idle(2);
  endtask

  task automatic test_circle();
    cur = "circle";
    set_spr(0, 100, 100, 4, 24'h33cc99, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 103, 103);
    cycle(1'b0, 1'b1, 104, 100);
    cycle(1'b0, 1'b1, 100, 96);
    cycle(1'b0, 1'b1, 97, 103);
    cycle(1'b0, 1'b1, 98, 97);
    idle(2);
  endtask

  task automatic test_priority();
    cur = "priority";
    set_spr(0, 50, 50, 6, 24'hff0000, 1'b1, 1'b0, 1'b0);
    set_spr(1, 50, 50, 8, 24'h00ff00, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 50, 50);
    cycle(1'b0, 1'b1, 57, 50);
    SprEn[0] = 1'b0;
    // Without frame_start the disable is not yet visible.
    cycle(1'b0, 1'b1, 50, 50);
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 50, 50);
    cycle(1'b0, 1'b1, 52, 48);
    SprEn = '0;
    cycle(1'b1, 1'b0, 0, 0);
    idle(2);
  endtask

  task automatic test_edges();
    cur = "edges";
    set_spr(0, 2, 300, 4, 24'habcdef, 1'b1, 1'b0, 1'b0);
    set_spr(1, 1020, 10, 10, 24'h123456, 1'b1, 1'b0, 1'b0);
    set_spr(2, 0, 0, 3, 24'h0f0f0f, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 0, 300);
    cycle(1'b0, 1'b1, 6, 300);
    cycle(1'b0, 1'b1, 7, 300);
    cycle(1'b0, 1'b1, 1023, 300);
    cycle(1'b0, 1'b1, 1023, 10);
    cycle(1'b0, 1'b1, 1009, 10);
    cycle(1'b0, 1'b1, 1010, 0);
    cycle(1'b0, 1'b1, 0, 1023);
    cycle(1'b0, 1'b1, 1023, 1023);
    cycle(1'b0, 1'b1, 2, 1);
    SprEn = '0;
    cycle(1'b1, 1'b0, 0, 0);
    idle(2);
  endtask

  task automatic test_blink();
    cur = "blink";
    SprEn = '0;
    do_reset();
    set_spr(0, 200, 200, 5, 24'h12ab34, 1'b1, 1'b0, 1'b1);
    set_spr(1, 200, 200, 9, 24'h777777, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 6; f++) begin
      cycle(1'b0, 1'b1, 200, 200);
      cycle(1'b0, 1'b1, 203, 198);
      cycle(1'b0, 1'b1, 208, 200);
      cycle(1'b1, 1'b0, 0, 0);
    end
    // Moving the sprite without a frame_start must not affect drawing.
    SprX[0 +: CW] = CW'(500);
    cycle(1'b0, 1'b1, 200, 200);
    cycle(1'b0, 1'b1, 500, 200);
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 200, 200);
    cycle(1'b0, 1'b1, 500, 200);
    idle(2);
  endtask

  task automatic test_reset_midline();
    cur = "reset_midline";
    set_spr(0, 300, 300, 40, 24'hc0ffee, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 300, 300);
    cycle(1'b0, 1'b1, 301, 300);
    do_reset();
    cycle(1'b0, 1'b1, 300, 300);
    cycle(1'b0, 1'b1, 301, 300);
    cycle(1'b0, 1'b1, 40, 300);
    idle(2);
  endtask

  task automatic test_random();
    int j, px, py;
    bit fs, pv;
    cur = "random";
    for (int i = 0; i < N; i++)
      set_spr(i, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 50),
              24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    cycle(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        j = $urandom_range(0, N - 1);
        set_spr(j, $urandom_range(0, 1023), $urandom_range(0, 1023),
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 50),
                24'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
      end
      fs = ($urandom_range(0, 49) == 0);
      pv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        px = $urandom_range(0, 1023);
        py = $urandom_range(0, 1023);
      end else begin
        j  = $urandom_range(0, N - 1);
        px = m_x[j] + int'($urandom_range(0, 140)) - 70;
        py = m_y[j] + int'($urandom_range(0, 140)) - 70;
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        if (py < 0) py = 0;
        if (py > 1023) py = 1023;
      end
      cycle(fs, pv, px, py);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_square();
    test_circle();
    test_priority();
    test_edges();
    test_blink();
    test_reset_midline();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
